tdc_capture_seq: RTL and testbench

TDC_CAPTURE_SEQ -- requirements
Module: tdc_capture_seq

---
 rtl/tdc_capture_seq.sv | 141 ++++++++++++++
 tb/tb_tdc_capture_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_capture_seq.sv
// TDC capture sequencer: registers thermometer samples, converts them to
// counts and accumulates min/max/sum/bubble over a run of N samples.
module tdc_capture_seq #(
    parameter int TDC_WIDTH     = 32,
    parameter int CNT_W         = 6,
    parameter int NSAMP_W       = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [TDC_WIDTH-1:0]     tdc_data,
    input  logic                     start,
    input  logic                     abort,
    input  logic [NSAMP_W-1:0]       num_samples,
    output logic                     busy,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [CNT_W-1:0]         res_min,
    output logic [CNT_W-1:0]         res_max,
    output logic [CNT_W+NSAMP_W-1:0] res_sum,
    output logic                     res_bubble
);
    localparam int SUM_W = CNT_W + NSAMP_W;
    localparam int NC_W  = NSAMP_W + 1;

    typedef enum logic [1:0] {IDLE, SETTLE, ACQ, DONE} state_t;

    state_t              state;
    logic [TDC_WIDTH-1:0] sample_q;
    logic [3:0]          settle_cnt;
    logic [NC_W-1:0]     smp_cnt;
    logic [NC_W-1:0]     n_lat;
    logic [CNT_W-1:0]    acc_min;
    logic [CNT_W-1:0]    acc_max;
    logic [SUM_W-1:0]    acc_sum;
    logic                acc_bub;

    logic [CNT_W-1:0]    cnt;
    logic                bub;
    logic                found;
    logic                first;
    logic [CNT_W-1:0]    nxt_min;
    logic [CNT_W-1:0]    nxt_max;
    logic [SUM_W-1:0]    nxt_sum;
    logic                nxt_bub;

    // Lowest zero gives the count; any one above it marks a bubble.
    always_comb begin
        cnt   = CNT_W'(TDC_WIDTH);
        bub   = 1'b0;
        found = 1'b0;
        for (int i = 0; i < TDC_WIDTH; i++) begin
            if (!found && !sample_q[i]) begin
                cnt   = CNT_W'(i);
                found = 1'b1;
            end else if (found && sample_q[i]) begin
                bub = 1'b1;
            end
        end
    end

    always_comb begin
        first   = (smp_cnt == '0);
        nxt_min = (first || cnt < acc_min) ? cnt : acc_min;
        nxt_max = (first || cnt > acc_max) ? cnt : acc_max;
        nxt_sum = (first ? '0 : acc_sum) + SUM_W'(cnt);
        nxt_bub = (first ? 1'b0 : acc_bub) | bub;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sample_q   <= '0;
            settle_cnt <= '0;
            smp_cnt    <= '0;
            n_lat      <= '0;
            acc_min    <= '0;
            acc_max    <= '0;
            acc_sum    <= '0;
            acc_bub    <= 1'b0;
            busy       <= 1'b0;
            res_valid  <= 1'b0;
            res_min    <= '0;
            res_max    <= '0;
            res_sum    <= '0;
            res_bubble <= 1'b0;
        end else begin
            sample_q <= tdc_data;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        n_lat      <= (num_samples == '0) ? NC_W'(1)
                                                          : {1'b0, num_samples};
                        smp_cnt    <= '0;
                        settle_cnt <= '0;
                        busy       <= 1'b1;
                        state      <= (SETTLE_CYCLES == 0) ? ACQ : SETTLE;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (settle_cnt == 4'(SETTLE_CYCLES - 1)) begin
                        state <= ACQ;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                ACQ: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        acc_min <= nxt_min;
                        acc_max <= nxt_max;
                        acc_sum <= nxt_sum;
                        acc_bub <= nxt_bub;
                        smp_cnt <= smp_cnt + NC_W'(1);
                        if (smp_cnt + NC_W'(1) == n_lat) begin
                            res_min    <= nxt_min;
                            res_max    <= nxt_max;
                            res_sum    <= nxt_sum;
                            res_bubble <= nxt_bub;
                            res_valid  <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tdc_capture_seq.sv
// Randomised self-checking bench for tdc_capture_seq against a
// sample-list reference model.
module tb_tdc_capture_seq;
    localparam int W  = 32;
    localparam int CW = 6;
    localparam int NW = 8;
    localparam int ST = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [W-1:0]    tdc_data = '0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [NW-1:0]   num_samples = '0;
    logic            busy;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [CW-1:0]   res_min;
    logic [CW-1:0]   res_max;
    logic [CW+NW-1:0] res_sum;
    logic            res_bubble;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] smp[$];
    int pmin = 0, pmax = 0, psum = 0, pbub = 0;

    tdc_capture_seq #(
        .TDC_WIDTH(W), .CNT_W(CW), .NSAMP_W(NW), .SETTLE_CYCLES(ST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tdc_data(tdc_data), .start(start),
        .abort(abort), .num_samples(num_samples), .busy(busy),
        .res_valid(res_valid), .res_ready(res_ready), .res_min(res_min),
        .res_max(res_max), .res_sum(res_sum), .res_bubble(res_bubble)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, int got, int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int cnt_of(logic [W-1:0] d);
        for (int i = 0; i < W; i++) if (!d[i]) return i;
        return W;
    endfunction

    function automatic int bub_of(logic [W-1:0] d);
        int c = cnt_of(d);
        for (int i = c + 1; i < W; i++) if (d[i]) return 1;
        return 0;
    endfunction

    function automatic logic [W-1:0] thermo(int k);
        logic [63:0] t = (64'd1 << k) - 64'd1;
        return t[W-1:0];
    endfunction

    // Start a run on the samples in smp and stop once res_valid is seen.
    task automatic run_to_valid(int nreq, string tag);
        int n = (nreq == 0) ? 1 : nreq;
        int got = -1;
        int bad_busy = 0;
        int emin = W, emax = 0, esum = 0, ebub = 0;
        for (int i = 0; i < n; i++) begin
            int c = cnt_of(smp[i]);
            if (c < emin) emin = c;
            if (c > emax) emax = c;
            esum += c;
            ebub |= bub_of(smp[i]);
        end
        start = 1'b1;
        num_samples = NW'(nreq);
        tdc_data = (ST == 0) ? smp[0] : $urandom;
        for (int j = 1; j <= ST + n + 6 && got < 0; j++) begin
            @(posedge clk); #1;
            start = 1'b0;
            tdc_data = (j - ST >= 0 && j - ST < n) ? smp[j-ST] : $urandom;
            if (res_valid) begin
                got = j;
                res_ready = 1'b0;
            end else begin
                res_ready = 1'($urandom);
                if (!busy) bad_busy++;
            end
        end
        res_ready = 1'b0;
        check({tag, "_latency"}, got, ST + n + 1);
        check({tag, "_busy_run"}, bad_busy, 0);
        check({tag, "_min"}, int'(res_min), emin);
        check({tag, "_max"}, int'(res_max), emax);
        check({tag, "_sum"}, int'(res_sum), esum);
        check({tag, "_bubble"}, int'(res_bubble), ebub);
        pmin = emin; pmax = emax; psum = esum; pbub = ebub;
    endtask

    task automatic handshake(string tag);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check({tag, "_valid_drop"}, int'(res_valid), 0);
        check({tag, "_busy_drop"}, int'(busy), 0);
    endtask

    task automatic fill_const(int n, logic [W-1:0] v);
        smp.delete();
        for (int i = 0; i < n; i++) smp.push_back(v);
    endtask

    task automatic fill_rand(int n);
        smp.delete();
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 4) == 0) smp.push_back($urandom);
            else smp.push_back(thermo($urandom_range(0, W)));
        end
    endtask

    initial begin
        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(res_valid), 0);
        check("rst_sum", int'(res_sum), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        fill_const(4, 32'h0000FFFF);
        run_to_valid(4, "const");
        handshake("const");

        smp = '{32'h000000FF, 32'h00000FFF, 32'h0000000F};
        run_to_valid(3, "vary");
        handshake("vary");

        smp = '{32'h000100FF, 32'hFFFFFFFF, 32'h00000000};
        run_to_valid(3, "bubble");

        begin
            int unstable = 0;
            int vlow = 0;
            for (int k = 0; k < 10; k++) begin
                start = k[0];
                num_samples = NW'($urandom);
                @(posedge clk); #1;
                if (res_min !== 6'(pmin) || res_max !== 6'(pmax) ||
                    int'(res_sum) != psum || int'(res_bubble) != pbub)
                    unstable++;
                if (!res_valid) vlow++;
            end
            check("bp_stable", unstable, 0);
            check("bp_valid_held", vlow, 0);
            start = 1'b1;
            handshake("bp");
            start = 1'b0;
            @(posedge clk); #1;
            check("bp_no_start", int'(busy), 0);
        end

        begin
            int vseen = 0;
            start = 1'b1;
            num_samples = 8'd4;
            for (int j = 1; j <= ST + 2; j++) begin
                @(posedge clk); #1;
                start = 1'b0;
                tdc_data = $urandom;
                if (j == ST + 2) abort = 1'b1;
            end
            @(posedge clk); #1;
            abort = 1'b0;
            check("abort_busy", int'(busy), 0);
            for (int j = 0; j < 5; j++) begin
                if (res_valid) vseen++;
                abort = 1'($urandom);
                @(posedge clk); #1;
            end
            abort = 1'b0;
            check("abort_valid", vseen, 0);
            check("abort_keep_min", int'(res_min), pmin);
            check("abort_keep_sum", int'(res_sum), psum);
            check("abort_keep_bub", int'(res_bubble), pbub);
        end

        fill_rand(1);
        run_to_valid(0, "n0");
        handshake("n0");

        fill_rand(255);
        run_to_valid(255, "n255");
        handshake("n255");

        for (int r = 0; r < 20; r++) begin
            int n = $urandom_range(0, 12);
            fill_rand(n == 0 ? 1 : n);
            run_to_valid(n, $sformatf("rnd%0d", r));
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            handshake($sformatf("rnd%0d", r));
        end

        begin
            int bad_busy = 0;
            fill_rand(10);
            start = 1'b1;
            num_samples = 8'd10;
            for (int j = 1; j <= ST + 3; j++) begin
                @(posedge clk); #1;
                start = 1'b0;
                tdc_data = $urandom;
            end
            #2;
            rst_n = 1'b0;
            #1;
            check("arst_busy", int'(busy), 0);
            check("arst_valid", int'(res_valid), 0);
            check("arst_min", int'(res_min), 0);
            check("arst_max", int'(res_max), 0);
            check("arst_sum", int'(res_sum), 0);
            check("arst_bub", int'(res_bubble), 0);
            #7;
            rst_n = 1'b1;
            for (int j = 0; j < 6; j++) begin
                @(posedge clk); #1;
                if (busy || res_valid) bad_busy++;
            end
            check("arst_idle", bad_busy, 0);
            pmin = 0; pmax = 0; psum = 0; pbub = 0;
        end

        fill_const(2, 32'h00000007);
        run_to_valid(2, "post_rst");
        handshake("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
